// File: rtl/frame_blocker_pkg.sv
// Shared constants and FSM state type for the MFCC front-end frame blocker.
// Holds the default sample width used by every MFCC stage and the pre-emphasis shift.
package frame_blocker_pkg;

  localparam int MFCC_DATA_W   = 16;
  localparam int PREEMPH_SHIFT = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } fb_state_e;

endpackage

// File: rtl/frame_blocker_ram.sv
// Sample buffer for the frame blocker: one synchronous write port, one asynchronous read port.
// The array carries no reset; stale contents are never read because cnt gates emission.
module frame_buf_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frame_blocker.sv
// Splits the raw audio stream into overlapping FRAME_LEN-sample frames advancing by HOP_LEN.
// Define FRAME_PREEMPH_EN to apply y = x - (31/32)p pre-emphasis on the write path.
module frame_blocker
  import frame_blocker_pkg::*;
#(
  parameter int DATA_W    = MFCC_DATA_W,
  parameter int ADDR_W    = 9,
  parameter int FRAME_LEN = 256,
  parameter int HOP_LEN   = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              frame_start,
  output logic              frame_last
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   FRAME_CNT = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0]   HOP_CNT   = (ADDR_W+1)'(HOP_LEN);
  localparam logic [ADDR_W-1:0] HOP_PTR   = ADDR_W'(HOP_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_LEN - 1);

  fb_state_e         state, state_next;
  logic [ADDR_W-1:0] wr_ptr, base_ptr, rd_idx;
  logic [ADDR_W:0]   cnt, cnt_next;
  logic              wr_en, emit, beat, last_beat;
  logic [DATA_W-1:0] wr_data, rd_data;

  assign emit        = (state == ST_EMIT);
  assign in_ready    = (cnt != DEPTH_CNT);
  assign wr_en       = in_valid & in_ready & ~clear;
  assign beat        = emit & out_ready;
  assign last_beat   = beat & (rd_idx == LAST_IDX);
  assign out_valid   = emit;
  assign out_data    = emit ? rd_data : '0;
  assign frame_start = emit & (rd_idx == '0);
  assign frame_last  = emit & (rd_idx == LAST_IDX);

`ifdef FRAME_PREEMPH_EN
  logic signed [DATA_W-1:0] prev_sample;
  logic signed [DATA_W:0]   x_ext, p_ext, emph_wide;

  // Widen by one bit so the subtraction cannot wrap, then clamp back to DATA_W.
  always_comb begin
    x_ext     = {in_data[DATA_W-1], in_data};
    p_ext     = {prev_sample[DATA_W-1], prev_sample};
    emph_wide = x_ext - (p_ext - (p_ext >>> PREEMPH_SHIFT));
    wr_data   = emph_wide[DATA_W-1:0];
    if (emph_wide[DATA_W] != emph_wide[DATA_W-1])
      wr_data = emph_wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     prev_sample <= '0;
    else if (clear) prev_sample <= '0;
    else if (wr_en) prev_sample <= in_data;
  end
`else
  assign wr_data = in_data;
`endif

  frame_buf_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (base_ptr + rd_idx),
    .rdata (rd_data)
  );

  // A write and a frame release can land in the same cycle, so both adjust cnt together.
  always_comb begin
    cnt_next = cnt;
    if (wr_en)     cnt_next = cnt_next + 1'b1;
    if (last_beat) cnt_next = cnt_next - HOP_CNT;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cnt >= FRAME_CNT) state_next = ST_EMIT;
      ST_EMIT: if (last_beat)        state_next = ST_IDLE;
      default:                       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      base_ptr <= '0;
      rd_idx   <= '0;
      cnt      <= '0;
    end else if (clear) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      base_ptr <= '0;
      rd_idx   <= '0;
      cnt      <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (last_beat) begin
        rd_idx   <= '0;
        base_ptr <= base_ptr + HOP_PTR;
      end else if (beat) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_blocker.sv
// Directed bench for frame_blocker with DATA_W=16, ADDR_W=4, FRAME_LEN=8, HOP_LEN=4.
// The pre-emphasis section runs only when FRAME_PREEMPH_EN is defined.
module tb_frame_blocker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        frame_start;
  logic        frame_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepted = 0;
  logic obs_in_ready, obs_out_valid, obs_start, obs_accept;
  logic [15:0] obs_data;
  logic [15:0] q_data[$];
  logic        q_start[$];
  logic        q_last[$];
  int          q_cyc[$];

  frame_blocker #(
    .DATA_W    (16),
    .ADDR_W    (4),
    .FRAME_LEN (8),
    .HOP_LEN   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .frame_last  (frame_last)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe on the falling edge, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    obs_data      = out_data;
    obs_start     = frame_start;
    obs_accept    = in_valid & in_ready & ~clear;
    if (obs_accept) accepted++;
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_start.push_back(frame_start);
      q_last.push_back(frame_last);
      q_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic flush_log();
    q_data.delete();
    q_start.delete();
    q_last.delete();
    q_cyc.delete();
    accepted = 0;
  endtask

  task automatic apply_stimulus(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_output("beat_timeout", 32'(q_data.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int offset, input int first_val);
    for (int j = 0; j < 8; j++) begin
      check_output($sformatf("%s_data%0d", tag, j), 32'(q_data[offset+j]), 32'(16'(first_val + j)));
      check_output($sformatf("%s_start%0d", tag, j), 32'(q_start[offset+j]), 32'(j == 0));
      check_output($sformatf("%s_last%0d", tag, j), 32'(q_last[offset+j]), 32'(j == 7));
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    flush_log();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    clear     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #2;
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_frame_start", 32'(frame_start), 32'd0);
    check_output("rst_frame_last", 32'(frame_last), 32'd0);

    $display("[TB] single frame and hop wait");
    do_reset();
    for (int i = 1; i <= 8; i++) apply_stimulus(16'(i));
    wait_beats(8, 30);
    check_frame("t1_f1", 0, 1);
    repeat (6) tick();
    check_output("t1_hold_beats", 32'(q_data.size()), 32'd8);
    check_output("t1_hold_valid", 32'(obs_out_valid), 32'd0);
    for (int i = 9; i <= 11; i++) apply_stimulus(16'(i));
    repeat (4) tick();
    check_output("t1_short_beats", 32'(q_data.size()), 32'd8);
    apply_stimulus(16'd12);
    wait_beats(16, 30);
    check_frame("t1_f2", 8, 5);

    $display("[TB] continuous stream");
    do_reset();
    for (int i = 1; i <= 16; i++) apply_stimulus(16'(i));
    wait_beats(24, 60);
    check_output("t2_accepted", 32'(accepted), 32'd16);
    check_frame("t2_f1", 0, 1);
    check_frame("t2_f2", 8, 5);
    check_frame("t2_f3", 16, 9);
    check_output("t2_gap12", 32'(q_cyc[8] - q_cyc[7]), 32'd2);
    check_output("t2_gap23", 32'(q_cyc[16] - q_cyc[15]), 32'd2);

    $display("[TB] backpressure");
    do_reset();
    out_ready = 1'b0;
    begin
      int nxt = 1;
      for (int i = 0; i < 20; i++) begin
        in_valid = 1'b1;
        in_data  = 16'(nxt);
        tick();
        if (obs_accept) nxt++;
      end
    end
    in_valid = 1'b0;
    check_output("t3_accepted", 32'(accepted), 32'd16);
    check_output("t3_in_ready_low", 32'(obs_in_ready), 32'd0);
    check_output("t3_stall_valid", 32'(obs_out_valid), 32'd1);
    check_output("t3_stall_data", 32'(obs_data), 32'd1);
    check_output("t3_stall_start", 32'(obs_start), 32'd1);
    check_output("t3_no_beats", 32'(q_data.size()), 32'd0);
    out_ready = 1'b1;
    wait_beats(8, 30);
    check_frame("t3_f1", 0, 1);
    check_output("t3_ready_at_last", 32'(obs_in_ready), 32'd0);
    tick();
    check_output("t3_ready_after_last", 32'(obs_in_ready), 32'd1);

    $display("[TB] clear mid-frame");
    do_reset();
    for (int i = 1; i <= 8; i++) apply_stimulus(16'(i));
    wait_beats(3, 30);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_output("t4_idx3_data", 32'(q_data[3]), 32'd4);
    tick();
    check_output("t4_valid_after_clear", 32'(obs_out_valid), 32'd0);
    check_output("t4_ready_after_clear", 32'(obs_in_ready), 32'd1);
    flush_log();
    for (int i = 100; i <= 107; i++) apply_stimulus(16'(i));
    wait_beats(8, 30);
    check_frame("t4_f1", 0, 100);

    $display("[TB] async reset mid-frame");
    do_reset();
    for (int i = 1; i <= 8; i++) apply_stimulus(16'(i));
    wait_beats(2, 30);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t5_in_ready", 32'(in_ready), 32'd1);
    check_output("t5_out_valid", 32'(out_valid), 32'd0);
    check_output("t5_out_data", 32'(out_data), 32'd0);
    check_output("t5_frame_start", 32'(frame_start), 32'd0);
    check_output("t5_frame_last", 32'(frame_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    flush_log();
    for (int i = 11; i <= 18; i++) apply_stimulus(16'(i));
    wait_beats(8, 30);
    check_frame("t5_f1", 0, 11);

`ifdef FRAME_PREEMPH_EN
    $display("[TB] pre-emphasis");
    do_reset();
    begin
      logic [15:0] stim [8];
      logic [15:0] expv [8];
      stim = '{16'h0020, 16'h0020, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      expv = '{16'h0020, 16'h0001, 16'h8000, 16'hFC00, 16'h7C00, 16'h0000, 16'h0000, 16'h0000};
      for (int i = 0; i < 8; i++) apply_stimulus(stim[i]);
      wait_beats(8, 30);
      for (int i = 0; i < 8; i++)
        check_output($sformatf("t6_emph%0d", i), 32'(q_data[i]), 32'(expv[i]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
